// File: rtl/float_key_byte_extractor.sv
// Key-byte extractor after the float adder: takes an IEEE-754 single and
// emits one 8-bit window of its fixed-point magnitude through a 2-stage stallable pipe.
module float_key_byte_extractor #(
  parameter int SKIP  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_exc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic [CNT_W-1:0] out_count,
  output logic [7:0]       err_count
);

  logic             s1_valid_q, s1_bad_q;
  logic [23:0]      s1_sig_q;
  logic [9:0]       s1_shift_q;
  logic             s2_valid_q;
  logic [7:0]       s2_byte_q;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [7:0]       err_count_q, err_count_d;

  logic       advance, drop, out_xfer;
  logic [7:0] in_exp;
  logic [9:0] shift_d, neg_shift;
  logic [7:0] byte_d;

  assign advance  = !s2_valid_q || out_ready;
  assign in_ready = advance;
  assign drop     = advance && s1_valid_q && s1_bad_q;
  assign out_xfer = s2_valid_q && out_ready;

  assign in_exp = in_data[30:23];
  // Two's-complement left-shift amount; bit 9 is the sign.
  assign shift_d   = 10'(in_exp) + 10'(SKIP) - 10'd142;
  assign neg_shift = 10'd0 - s1_shift_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    byte_d = 8'h00;
    if (!s1_shift_q[9]) begin
      if (s1_shift_q < 10'd8) byte_d = s1_sig_q[7:0] << s1_shift_q[2:0];
    end else if (neg_shift < 10'd24) begin
      byte_d = 8'(s1_sig_q >> neg_shift[4:0]);
    end
  end

  assign out_count_d = out_count_q + CNT_W'(out_xfer);
  assign err_count_d = (drop && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_bad_q   <= 1'b0;
      s1_sig_q   <= '0;
      s1_shift_q <= '0;
      s2_valid_q <= 1'b0;
      s2_byte_q  <= 8'h00;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s1_bad_q   <= in_exc || (&in_exp);
      s1_sig_q   <= {|in_exp, in_data[22:0]};
      s1_shift_q <= shift_d;
      s2_valid_q <= s1_valid_q && !s1_bad_q;
      if (s1_valid_q && !s1_bad_q) s2_byte_q <= byte_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count_q <= '0;
      err_count_q <= 8'h00;
    end else begin
      out_count_q <= out_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_byte  = s2_byte_q;
  assign out_count = out_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_float_key_byte_extractor.sv
// Scoreboard bench: two instances (SKIP=0 and SKIP=8) share one input stream;
// expected bytes come from a real-arithmetic model of floor(|x|*2^(8+SKIP)) mod 256.
module tb_float_key_byte_extractor;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b8;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_exc;
  logic        out_ready;

  logic        in_ready0, out_valid0, in_ready8, out_valid8;
  logic [7:0]  out_byte0, out_byte8, err_count0, err_count8;
  logic [15:0] out_count0, out_count8;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_out = 0;
  int   exp_err = 0;
  int   stall_cnt = 0;
  logic stall_prev = 1'b0;
  logic [7:0] held0, held8;

  float_key_byte_extractor #(.SKIP(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_exc(in_exc), .out_valid(out_valid0), .out_ready(out_ready),
    .out_byte(out_byte0), .out_count(out_count0), .err_count(err_count0)
  );

  float_key_byte_extractor #(.SKIP(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data), .in_exc(in_exc), .out_valid(out_valid8), .out_ready(out_ready),
    .out_byte(out_byte8), .out_count(out_count8), .err_count(err_count8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] key_byte(input logic [31:0] d, input int skip);
    int      e;
    real     sig, v;
    longint  li;
    e   = int'(d[30:23]);
    sig = ((e != 0) ? 8388608.0 : 0.0) + real'(d[22:0]);
    v   = sig * (2.0 ** (e - 142 + skip));
    if (v >= 2.0 ** 40) return 8'h00;
    li = longint'($floor(v));
    return li[7:0];
  endfunction

  // Monitor: pops on output transfers, pushes on input transfers, checks stall holding.
  always @(negedge clk) begin
    exp_t ex;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(out_valid0), 32'd1);
        check("hold_byte0", 32'(out_byte0), 32'(held0));
        check("hold_byte8", 32'(out_byte8), 32'(held8));
      end
      if (out_valid0 && !out_ready) begin
        check("stall_in_ready", 32'(in_ready0), 32'd0);
        stall_prev = 1'b1;
        held0 = out_byte0;
        held8 = out_byte8;
        stall_cnt++;
      end else begin
        stall_prev = 1'b0;
      end
      if (out_ready && (out_valid0 || q.size() != 0)) begin
        if (q.size() == 0) begin
          check("spurious_out", 32'(out_valid0), 32'd0);
        end else if (out_valid0) begin
          ex = q.pop_front();
          check("byte_skip0", 32'(out_byte0), 32'(ex.b0));
          check("byte_skip8", 32'(out_byte8), 32'(ex.b8));
          check("valid_skip8", 32'(out_valid8), 32'd1);
          exp_out++;
        end
      end
      if (in_valid && in_ready0) begin
        check("in_ready_skip8", 32'(in_ready8), 32'd1);
        if (in_exc || in_data[30:23] == 8'hFF) begin
          if (exp_err < 255) exp_err++;
        end else begin
          ex.b0 = key_byte(in_data, 0);
          ex.b8 = key_byte(in_data, 8);
          q.push_back(ex);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic send(input logic [31:0] d, input logic x);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_exc   = x;
    @(negedge clk);
    while (!in_ready0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready0) check("send_timeout", 32'(in_ready0), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_exc   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("drain_timeout", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    check({tag, "_out_count0"}, 32'(out_count0), 32'(exp_out));
    check({tag, "_out_count8"}, 32'(out_count8), 32'(exp_out));
    check({tag, "_err_count"},  32'(err_count0), 32'(exp_err));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_exc = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_out_byte",  32'(out_byte0),  32'd0);
    check("rst_out_count", 32'(out_count0), 32'd0);
    check("rst_err_count", 32'(err_count0), 32'd0);
    check("rst_in_ready",  32'(in_ready0),  32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: transfer at edge N, out_valid seen high at edge N+2.
    send(32'h3F000000, 1'b0);
    @(negedge clk);
    check("lat_after_n", 32'(out_valid0), 32'd0);
    @(negedge clk);
    check("lat_after_n1", 32'(out_valid0), 32'd1);
    drain();

    // Back-to-back stream.
    send(32'h3F000000, 1'b0);
    send(32'h3F400000, 1'b0);
    send(32'h3F3504F3, 1'b0);
    drain();
    check_counts("stream");

    // Integer part discarded, sign ignored, zero/denormal.
    send(32'h3FC00000, 1'b0);
    send(32'hBF400000, 1'b0);
    send(32'h00000000, 1'b0);
    send(32'h00000001, 1'b0);
    send(32'h4B7FFFFF, 1'b0);
    send(32'h47800080, 1'b0);
    for (int i = 0; i < 24; i++) send($urandom, 1'b0);
    drain();
    check_counts("patterns");

    // Drops: exception flag, exponent 255, mixed with good items back to back.
    send(32'h7F800000, 1'b1);
    send(32'h3F000000, 1'b0);
    drain();
    check("err_one", 32'(err_count0), 32'd1);
    send(32'h3F400000, 1'b0);
    send(32'h7FC00001, 1'b0);
    send(32'h3F3504F3, 1'b1);
    send(32'h3F200000, 1'b0);
    drain();
    check_counts("drops");

    // Stall: out_ready low for 3 cycles after the first output.
    stall_cnt = 0;
    fork
      begin
        send(32'h3F100000, 1'b0);
        send(32'h3F480000, 1'b0);
        send(32'h3F6A0000, 1'b0);
        send(32'h3F0F0F0F, 1'b0);
      end
      begin
        n = 0;
        while (!out_valid0 && n < 50) begin
          @(negedge clk);
          n++;
        end
        if (!out_valid0) check("stall_wait_timeout", 32'(out_valid0), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_cycles", stall_cnt, 3);
    check_counts("stall");

    // Error counter saturation.
    for (int i = 0; i < 256; i++) send(32'h7F800000, 1'b0);
    drain();
    check("err_saturated", 32'(err_count0), 32'd255);
    check_counts("saturate");

    // Asynchronous reset with two items in flight.
    out_ready = 1'b0;
    send(32'h3F000000, 1'b0);
    send(32'h3F400000, 1'b0);
    @(negedge clk);
    check("rst_pre_valid", 32'(out_valid0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid0), 32'd0);
    check("rst_mid_count", 32'(out_count0), 32'd0);
    check("rst_mid_err",   32'(err_count0), 32'd0);
    q.delete();
    exp_out = 0;
    exp_err = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rst_no_leftover", 32'(out_valid0), 32'd0);
    check_counts("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
